aes_wb_sequencer: RTL and testbench
===================================

AES_WB_SEQUENCER -- requirements
Module: aes_wb_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0, byte base address of the AES Wishbone slave.
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum status polls before abort.
REQ-003 SHALL have parameter START_GAP, default 2, idle cycles between the start write and the first status poll.
REQ-004 wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 req_valid_i / req_ready_o  in/out  1/1  encryption request handshake.
REQ-007 req_pt_i  in  128  plaintext; req_key_i  in  192  AES-192 key.
REQ-008 rsp_valid_o / rsp_ready_i  out/in  1/1  result handshake.
REQ-009 rsp_ct_o  out  128  ciphertext; rsp_err_o  out  1  bus error or timeout.
REQ-010 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-011 wbm_adr_o 32, wbm_dat_o 32, wbm_sel_o 4, wbm_we_o 1, wbm_stb_o 1, wbm_cyc_o 1  out  Wishbone master.
REQ-012 wbm_dat_i 32, wbm_ack_i 1, wbm_err_i 1  in  Wishbone master return.

Function
REQ-013 Slave map, word index n at BASE_ADDR+4n: 0 start(bit0), 1..4 pt words LSW..MSW, 5..10 key words LSW..MSW, 11 status(bit0 = ct_valid), 12..15 ct words MSW..LSW.
REQ-014 Word mapping SHALL be: req_pt_i[31:0]->idx1 ... [127:96]->idx4; req_key_i[31:0]->idx5 ... [191:160]->idx10; idx12->rsp_ct_o[127:96] ... idx15->[31:0].
REQ-015 FSM states SHALL be IDLE, WKEY, WPT, START, GAP, POLL, RCT, RESP.
REQ-016 req_ready_o SHALL be high only in IDLE; on valid&ready the block captures pt and key and leaves IDLE.
REQ-017 IDLE->WKEY when no key is cached or the captured key differs from the cached key; otherwise IDLE->WPT.
REQ-018 WKEY writes idx5..10 in ascending order, then updates the key cache and sets key_loaded; WPT writes idx1..4 ascending; START writes 1 to idx0.
REQ-019 Each transfer SHALL drive cyc=stb=1 and sel=4'hF, and hold adr/dat/we stable until ack or err.
REQ-020 After each ack, stb and cyc SHALL be low for exactly one cycle before the next transfer, so the slave sees start return to 0.
REQ-021 GAP SHALL idle the bus START_GAP cycles, then enter POLL.
REQ-022 POLL reads idx11 repeatedly; bit0=1 goes to RCT; a 10-bit-wide-or-larger counter of polls reaching TIMEOUT goes to RESP with err=1.
REQ-023 RCT reads idx12..15 into rsp_ct_o, then enters RESP.
REQ-024 RESP asserts rsp_valid_o and holds rsp_ct_o/rsp_err_o stable until rsp_ready_i, then returns to IDLE.
REQ-025 A wbm_err_i in any state SHALL end the transfer, clear key_loaded, and go to RESP with rsp_err_o=1 and rsp_ct_o=0.
REQ-026 On timeout, key_loaded SHALL also be cleared.
REQ-027 Latency with a zero-wait slave and a cached key: 10 cycles of writes, START_GAP, 2 cycles per poll, then 8 cycles of reads to rsp_valid_o.

Reset
REQ-028 With wb_rst_i high at a clock edge, the FSM SHALL go to IDLE and all wbm_* outputs, rsp_valid_o, rsp_err_o, busy_o, key_loaded, and the counters SHALL clear to 0; rsp_ct_o SHALL clear to 0.
REQ-029 Reset mid-transfer SHALL drop cyc and stb on the following cycle without waiting for ack; a pending response is discarded.

Structure
REQ-030 Package aes_seq_pkg SHALL hold the state enum, the register-index constants (IDX_START..IDX_CT3), and the poll-counter width.
REQ-031 One sub-module, wb_master_xfer, SHALL perform a single Wishbone transfer (go/done/err, including the idle cycle) for the FSM.

Verification
REQ-032 Send the FIPS-197 AES-192 vector (key 000102..1617, pt 00112233..eeff) -> rsp_ct_o=dda97ca4864cdfe06eaf70a0ec0d7191, err=0, 11 writes observed.
REQ-033 Send a second request with the same key -> exactly 5 writes (idx1..4, idx0), with no key writes.
REQ-034 Hold status bit0=0 forever with TIMEOUT=8 -> 8 polls, then rsp_valid=1 and err=1; the next request rewrites the key.
REQ-035 Assert wbm_err_i on the idx3 write -> rsp_err=1, rsp_ct=0, FSM back to IDLE after rsp_ready.
REQ-036 Hold rsp_ready_i=0 for 20 cycles -> rsp_valid and rsp_ct are stable and req_ready stays 0.
REQ-037 Assert wb_rst_i during POLL -> the next cycle shows cyc=stb=0, busy=0, req_ready=1.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: FSM encodings, AES slave word indices and poll-counter width
package aes_seq_pkg;
    localparam logic [2:0] IDLE = 3'd0, WKEY = 3'd1, WPT = 3'd2, START = 3'd3,
                           GAP = 3'd4, POLL = 3'd5, RCT = 3'd6, RESP = 3'd7;
    localparam logic [3:0] IDX_START = 4'd0, IDX_PT0 = 4'd1, IDX_KEY0 = 4'd5,
                           IDX_STATUS = 4'd11, IDX_CT0 = 4'd12, IDX_CT3 = 4'd15;
    localparam int POLL_W = 16;
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [3:0] idx);
        return base + {26'd0, idx, 2'd0};
    endfunction
endpackage

// File: rtl/aes_wb_sequencer_if.sv
// aes_wb_sequencer_if: Wishbone bus between the sequencer (master) and the AES core (slave)
interface aes_wb_sequencer_if;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0] wbm_sel_o;
    logic wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_ack_i, wbm_err_i;
    modport master(output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
                   input wbm_dat_i, wbm_ack_i, wbm_err_i);
    modport slave(input wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
                  output wbm_dat_i, wbm_ack_i, wbm_err_i);
endinterface

// File: rtl/wb_master_xfer.sv
// wb_master_xfer: one Wishbone transfer per go; go is ignored while a cycle is open,
// so the cycle after ack/err is always idle on the bus.
module wb_master_xfer (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic go,
    input  logic we,
    input  logic [31:0] adr,
    input  logic [31:0] dat,
    output logic done,
    output logic err,
    output logic [31:0] rdata,
    aes_wb_sequencer_if.master wbm
);
    logic act;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            act <= 1'b0;
            wbm.wbm_adr_o <= '0;
            wbm.wbm_dat_o <= '0;
            wbm.wbm_we_o <= 1'b0;
        end else if (!act) begin
            act <= go;
            if (go) begin
                wbm.wbm_adr_o <= adr;
                wbm.wbm_dat_o <= dat;
                wbm.wbm_we_o <= we;
            end
        end else if (wbm.wbm_ack_i || wbm.wbm_err_i) begin
            act <= 1'b0;
        end
    end
    assign wbm.wbm_cyc_o = act;
    assign wbm.wbm_stb_o = act;
    assign wbm.wbm_sel_o = {4{act}};
    assign done = act && (wbm.wbm_ack_i || wbm.wbm_err_i);
    assign err = act && wbm.wbm_err_i;
    assign rdata = wbm.wbm_dat_i;
endmodule

// File: rtl/aes_wb_sequencer.sv
// aes_wb_sequencer: drives an AES-192 Wishbone slave through key/pt load, start,
// status polling and ciphertext readback; the key is only rewritten when it changes.
module aes_wb_sequencer
    import aes_seq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int TIMEOUT = 1024,
    parameter int START_GAP = 2
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic req_valid_i,
    output logic req_ready_o,
    input  logic [127:0] req_pt_i,
    input  logic [191:0] req_key_i,
    output logic rsp_valid_o,
    input  logic rsp_ready_i,
    output logic [127:0] rsp_ct_o,
    output logic rsp_err_o,
    output logic busy_o,
    aes_wb_sequencer_if.master wbm
);
    logic [2:0] state;
    logic [POLL_W-1:0] cnt;
    logic [127:0] pt_q, ct_q;
    logic [191:0] key_q, key_cache;
    logic key_loaded, err_q;
    logic go, we, done, xerr;
    logic [3:0] idx;
    logic [31:0] wdat, rdata;
    assign idx = state == WKEY ? IDX_KEY0 + cnt[3:0] :
                 state == WPT ? IDX_PT0 + cnt[3:0] :
                 state == START ? IDX_START :
                 state == POLL ? IDX_STATUS : IDX_CT0 + cnt[3:0];
    assign wdat = state == WKEY ? key_q[32*cnt[2:0] +: 32] :
                  state == WPT ? pt_q[32*cnt[1:0] +: 32] : 32'd1;
    assign we = state == WKEY || state == WPT || state == START;
    assign go = we || state == POLL || state == RCT;
    wb_master_xfer u_xfer (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .go(go),
        .we(we),
        .adr(word_addr(BASE_ADDR, idx)),
        .dat(wdat),
        .done(done),
        .err(xerr),
        .rdata(rdata),
        .wbm(wbm)
    );
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            cnt <= '0;
            pt_q <= '0;
            key_q <= '0;
            key_cache <= '0;
            ct_q <= '0;
            key_loaded <= 1'b0;
            err_q <= 1'b0;
        end else if (xerr) begin
            state <= RESP;
            ct_q <= '0;
            err_q <= 1'b1;
            key_loaded <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid_i) begin
                    pt_q <= req_pt_i;
                    key_q <= req_key_i;
                    ct_q <= '0;
                    err_q <= 1'b0;
                    cnt <= '0;
                    state <= (!key_loaded || req_key_i != key_cache) ? WKEY : WPT;
                end
                WKEY: if (done) begin
                    cnt <= cnt == POLL_W'(5) ? '0 : cnt + 1'b1;
                    if (cnt == POLL_W'(5)) begin
                        state <= WPT;
                        key_cache <= key_q;
                        key_loaded <= 1'b1;
                    end
                end
                WPT: if (done) begin
                    cnt <= cnt == POLL_W'(3) ? '0 : cnt + 1'b1;
                    state <= cnt == POLL_W'(3) ? START : WPT;
                end
                START: if (done) begin
                    cnt <= '0;
                    state <= START_GAP == 0 ? POLL : GAP;
                end
                GAP: begin
                    cnt <= cnt == POLL_W'(START_GAP - 1) ? '0 : cnt + 1'b1;
                    state <= cnt == POLL_W'(START_GAP - 1) ? POLL : GAP;
                end
                POLL: if (done) begin
                    if (rdata[0]) begin
                        cnt <= '0;
                        state <= RCT;
                    end else if (cnt == POLL_W'(TIMEOUT - 1)) begin
                        state <= RESP;
                        err_q <= 1'b1;
                        key_loaded <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RCT: if (done) begin
                    // idx12 is the most significant ciphertext word
                    ct_q[32*(3 - cnt[1:0]) +: 32] <= rdata;
                    cnt <= cnt + 1'b1;
                    state <= idx == IDX_CT3 ? RESP : RCT;
                end
                default: if (rsp_ready_i) state <= IDLE;
            endcase
        end
    end
    assign req_ready_o = state == IDLE;
    assign busy_o = state != IDLE;
    assign rsp_valid_o = state == RESP;
    assign rsp_ct_o = ct_q;
    assign rsp_err_o = err_q;
endmodule

// File: tb/tb_aes_wb_sequencer.sv
// tb_aes_wb_sequencer: scoreboard bench with a zero-wait AES slave model on the Wishbone side
module tb_aes_wb_sequencer;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [191:0] KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT3 = 128'hcafef00d_deadbeef_0badc0de_13579bdf;
    typedef struct {
        logic [127:0] ct;
        logic err;
        int wr;
        int kwr;
        int polls;
        int lat;
    } exp_t;
    logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
    logic req_valid_i = 1'b0, req_ready_o, rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o, busy_o;
    logic [127:0] req_pt_i = '0, rsp_ct_o, slave_ct = '0;
    logic [191:0] req_key_i = '0;
    aes_wb_sequencer_if bus();
    aes_wb_sequencer #(.BASE_ADDR(BASE), .TIMEOUT(8), .START_GAP(2)) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_pt_i(req_pt_i),
        .req_key_i(req_key_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_ct_o(rsp_ct_o),
        .rsp_err_o(rsp_err_o),
        .busy_o(busy_o),
        .wbm(bus)
    );
    always #5 wb_clk_i = ~wb_clk_i;
    logic [31:0] regs [16];
    logic [31:0] off;
    logic [3:0] idx;
    logic hit, stall = 1'b0, prev_end = 1'b0;
    int ready_after = 0, err_idx = -1;
    int poll_total = 0, poll_base = 0, wr_total = 0, kwr_total = 0, viol = 0;
    int wr0, kwr0, poll0, viol0, n_chk = 0, n_pass = 0;
    exp_t sb[$];
    assign off = bus.wbm_adr_o - BASE;
    assign idx = off[5:2];
    assign hit = bus.wbm_cyc_o && bus.wbm_stb_o;
    assign bus.wbm_err_i = hit && bus.wbm_we_o && int'(idx) == err_idx;
    assign bus.wbm_ack_i = hit && !bus.wbm_err_i && !stall;
    always_comb
        bus.wbm_dat_i = idx == 4'd11 ? {31'd0, (poll_total - poll_base) >= ready_after} :
                        idx >= 4'd12 ? slave_ct[32*(15 - int'(idx)) +: 32] : 32'd0;
    // bus monitor: slave register file, transfer counters and protocol violations
    always @(posedge wb_clk_i) begin
        viol <= viol + ((hit && (bus.wbm_sel_o != 4'hF || off > 32'd63)) ? 1 : 0)
                     + ((hit && prev_end) ? 1 : 0);
        prev_end <= hit && (bus.wbm_ack_i || bus.wbm_err_i) && !wb_rst_i;
        if (bus.wbm_ack_i && bus.wbm_we_o) begin
            regs[idx] <= bus.wbm_dat_o;
            wr_total <= wr_total + 1;
            if (idx >= 4'd5 && idx <= 4'd10) kwr_total <= kwr_total + 1;
            if (idx == 4'd0) poll_base <= poll_total;
        end
        if (bus.wbm_ack_i && !bus.wbm_we_o && idx == 4'd11) poll_total <= poll_total + 1;
    end
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic issue(input logic [127:0] pt, input logic [191:0] key, input exp_t e);
        chk("req_ready", req_ready_o, 1);
        wr0 = wr_total;
        kwr0 = kwr_total;
        poll0 = poll_total;
        viol0 = viol;
        sb.push_back(e);
        req_pt_i = pt;
        req_key_i = key;
        req_valid_i = 1'b1;
        @(posedge wb_clk_i); #1;
        req_valid_i = 1'b0;
    endtask
    task automatic collect(input int hold);
        exp_t e;
        int lat = 0;
        logic [127:0] snap;
        logic stable = 1'b1;
        while (!rsp_valid_o && lat < 400) begin
            @(posedge wb_clk_i); #1;
            lat++;
        end
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid_o, 1);
        chk("latency", lat, e.lat);
        chk("ct", rsp_ct_o, e.ct);
        chk("err", rsp_err_o, e.err);
        chk("writes", wr_total - wr0, e.wr);
        chk("key_writes", kwr_total - kwr0, e.kwr);
        chk("polls", poll_total - poll0, e.polls);
        chk("protocol", viol - viol0, 0);
        snap = rsp_ct_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge wb_clk_i); #1;
            stable &= rsp_valid_o && rsp_ct_o == snap && rsp_err_o == e.err && !req_ready_o;
        end
        if (hold > 0) chk("hold_stable", stable, 1);
        rsp_ready_i = 1'b1;
        @(posedge wb_clk_i); #1;
        rsp_ready_i = 1'b0;
        chk("idle_ready", req_ready_o, 1);
        chk("idle_busy", busy_o, 0);
    endtask
    initial begin
        int n;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_cyc", bus.wbm_cyc_o, 0);
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_ct", rsp_ct_o, 0);
        chk("rst_err", rsp_err_o, 0);
        wb_rst_i = 1'b0;
        slave_ct = CT1;
        issue(PT, KEY, '{ct: CT1, err: 1'b0, wr: 11, kwr: 6, polls: 1, lat: 34});
        collect(0);
        chk("map_pt0", regs[1], 32'hccddeeff);
        chk("map_pt3", regs[4], 32'h00112233);
        chk("map_key0", regs[5], 32'h14151617);
        chk("map_key5", regs[10], 32'h00010203);
        chk("map_start", regs[0], 32'd1);
        slave_ct = CT2;
        issue(~PT, KEY, '{ct: CT2, err: 1'b0, wr: 5, kwr: 0, polls: 1, lat: 22});
        collect(20);
        ready_after = 1 << 20;
        issue(PT, KEY, '{ct: 128'd0, err: 1'b1, wr: 5, kwr: 0, polls: 8, lat: 28});
        collect(0);
        ready_after = 0;
        err_idx = 3;
        issue(PT, KEY, '{ct: 128'd0, err: 1'b1, wr: 8, kwr: 6, polls: 0, lat: 18});
        collect(0);
        err_idx = -1;
        ready_after = 2;
        slave_ct = CT3;
        issue(PT ^ 128'h5a, KEY, '{ct: CT3, err: 1'b0, wr: 11, kwr: 6, polls: 3, lat: 38});
        collect(0);
        ready_after = 1 << 20;
        issue(PT, KEY, '{ct: 128'd0, err: 1'b0, wr: 0, kwr: 0, polls: 0, lat: 0});
        n = 0;
        while (poll_total == poll0 && n < 200) begin
            @(posedge wb_clk_i); #1;
            n++;
        end
        chk("poll_seen", poll_total != poll0, 1);
        @(posedge wb_clk_i); #1;
        chk("poll_stb", bus.wbm_stb_o, 1);
        stall = 1'b1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        chk("mid_rst_cyc", bus.wbm_cyc_o, 0);
        chk("mid_rst_stb", bus.wbm_stb_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ready", req_ready_o, 1);
        chk("mid_rst_valid", rsp_valid_o, 0);
        wb_rst_i = 1'b0;
        stall = 1'b0;
        sb.delete();
        ready_after = 0;
        slave_ct = CT1;
        issue(PT, KEY, '{ct: CT1, err: 1'b0, wr: 11, kwr: 6, polls: 1, lat: 34});
        collect(0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
